ifetch_unit: RTL and testbench

- Reads the instruction addressed by the PC register's `pc` output from a variable-latency instruction memory.
- Holds the fetched instruction stable for the decoder and drives `stall` back to the PC logic, so the PC advances only when an instruction has been consumed.
- Adds a per-request watchdog and a redirect (flush) path.
- Sits between the PC register, the instruction memory port and the decode stage.

---
 rtl/ifetch_unit_if.sv | 29 ++
 rtl/ifetch_unit.sv | 134 +++++++++++++
 tb/tb_ifetch_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch unit bundle: PC, instruction memory and decoder signals
interface ifetch_unit_if #(
    parameter int ADDR_W = 30
);
    logic [31:0]       pc;
    logic              redirect;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              instr_valid;
    logic              dec_ready;
    logic              stall;
    logic              fetch_err;

    // Fetch unit side
    modport master (
        input  pc, redirect, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, instr, instr_pc, instr_valid, stall, fetch_err
    );

    // PC register, instruction memory and decoder side
    modport slave (
        output pc, redirect, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, stall, fetch_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-outstanding instruction fetch with watchdog and redirect
module ifetch_unit #(
    parameter int          ADDR_W    = 30,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Last WAIT-cycle count value before the fetch is declared lost
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_imem_req;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_req_pc;
    logic [7:0]        r_cnt;
    logic [31:0]       r_instr;
    logic [31:0]       r_instr_pc;
    logic              r_instr_valid;
    logic              r_fetch_err;

    state_t            w_state_nxt;
    logic              w_imem_req_nxt;
    logic [ADDR_W-1:0] w_imem_addr_nxt;
    logic [31:0]       w_req_pc_nxt;
    logic [7:0]        w_cnt_nxt;
    logic [31:0]       w_instr_nxt;
    logic [31:0]       w_instr_pc_nxt;
    logic              w_instr_valid_nxt;
    logic              w_fetch_err_nxt;
    logic [31:0]       w_pc_word;

    // Word-aligned view of the incoming PC; byte offset bits are dropped
    assign w_pc_word = {bus.pc[31:2], 2'b00};

    // State and datapath registers; reset drops any request and held instruction at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= '0;
            r_req_pc      <= '0;
            r_cnt         <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_imem_addr   <= w_imem_addr_nxt;
            r_req_pc      <= w_req_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_fetch_err   <= w_fetch_err_nxt;
        end
    end

    // Next-state logic: issue in IDLE, collect or time out in WAIT, present in HOLD
    always_comb begin
        w_state_nxt       = r_state;
        w_imem_req_nxt    = r_imem_req;
        w_imem_addr_nxt   = r_imem_addr;
        w_req_pc_nxt      = r_req_pc;
        w_cnt_nxt         = r_cnt;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_fetch_err_nxt   = r_fetch_err;

        case (r_state)
            S_IDLE: begin
                w_imem_req_nxt  = 1'b1;
                w_imem_addr_nxt = w_pc_word[ADDR_W+1:2];
                w_req_pc_nxt    = w_pc_word;
                w_cnt_nxt       = '0;
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    // Flush wins over a same-cycle response; the data is dropped
                    w_imem_req_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else if (bus.imem_rvalid) begin
                    w_instr_nxt       = bus.imem_rdata;
                    w_instr_pc_nxt    = r_req_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_imem_req_nxt    = 1'b0;
                    w_state_nxt       = S_HOLD;
                end else if (r_cnt == CNT_LAST) begin
                    // Memory never answered: hand the decoder a NOP and flag it
                    w_instr_nxt       = NOP_INSTR;
                    w_instr_pc_nxt    = r_req_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_fetch_err_nxt   = 1'b1;
                    w_imem_req_nxt    = 1'b0;
                    w_state_nxt       = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (bus.dec_ready || bus.redirect) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_imem_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.fetch_err   = r_fetch_err;
    // PC may only advance on the edge that completes the decoder handshake
    assign bus.stall       = ~(r_instr_valid & bus.dec_ready);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
module tb_ifetch_unit;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t e;

    ifetch_unit_if #(.ADDR_W(30)) bus ();
    ifetch_unit_if #(.ADDR_W(30)) tbus ();

    ifetch_unit #(.ADDR_W(30)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ifetch_unit #(.ADDR_W(30), .TIMEOUT(4), .NOP_INSTR(32'h0000_0000)) u_dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tbus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.redirect     = 1'b0;
        tbus.imem_rvalid = 1'b0;
        tbus.redirect    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pop_expected(output exp_t x, output bit ok);
        n_vec++;
        ok = (exp_q.size() != 0);
        x  = '0;
        if (!ok) begin
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected >= 1");
        end else begin
            x = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        bus.pc = 32'h40; bus.dec_ready = 1'b1; bus.imem_rdata = '0;
        bus.imem_rvalid = 1'b0; bus.redirect = 1'b0;
        tbus.pc = 32'h200; tbus.dec_ready = 1'b0; tbus.imem_rdata = '0;
        tbus.imem_rvalid = 1'b0; tbus.redirect = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
        n_vec++; if (bus.imem_addr !== 30'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
        n_vec++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h expected 0", bus.instr); end
        n_vec++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc: got %h expected 0", bus.instr_pc); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
        n_vec++; if (bus.fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", bus.fetch_err); end
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b expected 1", bus.stall); end
    endtask

    task automatic test_basic();
        bit ok;
        bus.pc = 32'h40; bus.dec_ready = 1'b1;
        do_reset();
        @(negedge clk);
        n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req: got %b expected 1", bus.imem_req); end
        n_vec++; if (bus.imem_addr !== 30'h10) begin n_err++; $display("FAIL basic_addr: got %h expected 10", bus.imem_addr); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2008_0005;
        exp_q.push_back({32'h2008_0005, 32'h40});
        @(negedge clk);
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'hxxxx_xxxx; bus.pc = 32'h44;
        n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", bus.instr_valid); end
        pop_expected(e, ok);
        n_vec++; if (ok && bus.instr !== e.data) begin n_err++; $display("FAIL basic_instr: got %h expected %h", bus.instr, e.data); end
        n_vec++; if (ok && bus.instr_pc !== e.pc) begin n_err++; $display("FAIL basic_instr_pc: got %h expected %h", bus.instr_pc, e.pc); end
        #1;
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL basic_stall_low: got %b expected 0", bus.stall); end
        @(negedge clk);
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL basic_stall_back: got %b expected 1", bus.stall); end
        n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL basic_idle_req: got %b expected 0", bus.imem_req); end
        @(negedge clk);
        n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL basic_next_req: got %b expected 1", bus.imem_req); end
        n_vec++; if (bus.imem_addr !== 30'h11) begin n_err++; $display("FAIL basic_next_addr: got %h expected 11", bus.imem_addr); end
    endtask

    task automatic test_latency();
        bit ok;
        bus.pc = 32'h80; bus.dec_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL lat_req[%0d]: got %b expected 1", i, bus.imem_req); end
            n_vec++; if (bus.imem_addr !== 30'h20) begin n_err++; $display("FAIL lat_addr[%0d]: got %h expected 20", i, bus.imem_addr); end
            n_vec++; if (bus.stall !== 1'b1 || bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL lat_stall[%0d]: got stall %b valid %b expected 1 0", i, bus.stall, bus.instr_valid); end
        end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA5A5_0001;
        exp_q.push_back({32'hA5A5_0001, 32'h80});
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid: got %b expected 1", bus.instr_valid); end
        pop_expected(e, ok);
        n_vec++; if (ok && (bus.instr !== e.data || bus.instr_pc !== e.pc)) begin n_err++; $display("FAIL lat_data: got %h/%h expected %h/%h", bus.instr, bus.instr_pc, e.data, e.pc); end
    endtask

    task automatic test_hold();
        bit ok;
        bus.pc = 32'hC0; bus.dec_ready = 1'b0;
        do_reset();
        @(negedge clk);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        exp_q.push_back({32'hDEAD_BEEF, 32'hC0});
        @(negedge clk);
        bus.imem_rvalid = 1'b0; bus.pc = 32'hC4;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_vec++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hDEAD_BEEF || bus.instr_pc !== 32'hC0) begin n_err++; $display("FAIL hold_stable[%0d]: got %b %h %h expected 1 deadbeef c0", k, bus.instr_valid, bus.instr, bus.instr_pc); end
            n_vec++; if (bus.stall !== 1'b1 || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL hold_stall[%0d]: got stall %b req %b expected 1 0", k, bus.stall, bus.imem_req); end
        end
        bus.dec_ready = 1'b1;
        #1;
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b expected 0", bus.stall); end
        pop_expected(e, ok);
        n_vec++; if (ok && bus.instr !== e.data) begin n_err++; $display("FAIL hold_instr: got %h expected %h", bus.instr, e.data); end
        @(negedge clk);
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL hold_done: got %b expected 0", bus.instr_valid); end
        @(negedge clk);
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h31) begin n_err++; $display("FAIL hold_next: got %b %h expected 1 31", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_timeout();
        bit ok;
        tbus.pc = 32'h200; tbus.dec_ready = 1'b0;
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'h200});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (tbus.imem_req !== 1'b1 || tbus.imem_addr !== 30'h80) begin n_err++; $display("FAIL to_wait[%0d]: got %b %h expected 1 80", i, tbus.imem_req, tbus.imem_addr); end
            n_vec++; if (tbus.instr_valid !== 1'b0 || tbus.fetch_err !== 1'b0) begin n_err++; $display("FAIL to_early[%0d]: got valid %b err %b expected 0 0", i, tbus.instr_valid, tbus.fetch_err); end
        end
        @(negedge clk);
        n_vec++; if (tbus.instr_valid !== 1'b1 || tbus.fetch_err !== 1'b1 || tbus.imem_req !== 1'b0) begin n_err++; $display("FAIL to_fire: got valid %b err %b req %b expected 1 1 0", tbus.instr_valid, tbus.fetch_err, tbus.imem_req); end
        pop_expected(e, ok);
        n_vec++; if (ok && (tbus.instr !== e.data || tbus.instr_pc !== e.pc)) begin n_err++; $display("FAIL to_nop: got %h/%h expected %h/%h", tbus.instr, tbus.instr_pc, e.data, e.pc); end
        tbus.imem_rvalid = 1'b1; tbus.imem_rdata = 32'h3333_3333;
        @(negedge clk);
        tbus.imem_rvalid = 1'b0;
        n_vec++; if (tbus.instr !== 32'h0 || tbus.instr_valid !== 1'b1) begin n_err++; $display("FAIL to_late_rvalid: got %h %b expected 0 1", tbus.instr, tbus.instr_valid); end
        tbus.dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (tbus.fetch_err !== 1'b1 || tbus.imem_req !== 1'b1) begin n_err++; $display("FAIL to_sticky: got err %b req %b expected 1 1", tbus.fetch_err, tbus.imem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (tbus.fetch_err !== 1'b0) begin n_err++; $display("FAIL to_err_clear: got %b expected 0", tbus.fetch_err); end
        tbus.dec_ready = 1'b0;
    endtask

    task automatic test_redirect();
        bit ok;
        bus.pc = 32'h40; bus.dec_ready = 1'b1;
        do_reset();
        @(negedge clk);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_1111;
        bus.redirect = 1'b1; bus.pc = 32'h100;
        @(negedge clk);
        bus.imem_rvalid = 1'b0; bus.redirect = 1'b0;
        n_vec++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL redir_flush: got valid %b req %b expected 0 0", bus.instr_valid, bus.imem_req); end
        @(negedge clk);
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h40) begin n_err++; $display("FAIL redir_newaddr: got %b %h expected 1 40", bus.imem_req, bus.imem_addr); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2222_2222;
        exp_q.push_back({32'h2222_2222, 32'h100});
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        pop_expected(e, ok);
        n_vec++; if (ok && (bus.instr_valid !== 1'b1 || bus.instr !== e.data || bus.instr_pc !== e.pc)) begin n_err++; $display("FAIL redir_refetch: got %b %h/%h expected 1 %h/%h", bus.instr_valid, bus.instr, bus.instr_pc, e.data, e.pc); end
    endtask

    task automatic test_async_reset();
        bit ok;
        bus.pc = 32'h40; bus.dec_ready = 1'b1;
        do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.stall !== 1'b1) begin n_err++; $display("FAIL areset_wait: got req %b valid %b stall %b expected 0 0 1", bus.imem_req, bus.instr_valid, bus.stall); end
        bus.pc = 32'h300; bus.dec_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'hC0) begin n_err++; $display("FAIL areset_restart: got %b %h expected 1 c0", bus.imem_req, bus.imem_addr); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h4444_4444;
        exp_q.push_back({32'h4444_4444, 32'h300});
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        pop_expected(e, ok);
        n_vec++; if (ok && (bus.instr_valid !== 1'b1 || bus.instr !== e.data)) begin n_err++; $display("FAIL areset_hold: got %b %h expected 1 %h", bus.instr_valid, bus.instr, e.data); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.stall !== 1'b1) begin n_err++; $display("FAIL areset_hold_drop: got valid %b instr %h stall %b expected 0 0 1", bus.instr_valid, bus.instr, bus.stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_hold();
        test_timeout();
        test_redirect();
        test_async_reset();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
